// File: rtl/mfcc_pkg.sv
// Shared types and default sizing for the MFCC front-end sequencing blocks.
package mfcc_pkg;
    localparam int NUM_FILTERS = 40;
    localparam int EW          = 9;
    localparam int TIMEOUT_W   = 16;

    typedef enum logic [1:0] {IDLE, START, RUN, RELEASE} sched_state_t;
endpackage

// File: rtl/energy_pingpong_ram.sv
// Two banks of NF filter energies: one write port, one registered read port.
module energy_pingpong_ram import mfcc_pkg::*; #(
    parameter int NF = NUM_FILTERS,
    parameter int W  = EW
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         we,
    input  logic         wbank,
    input  logic [5:0]   waddr,
    input  logic [W-1:0] wdata,
    input  logic         rbank,
    input  logic [5:0]   raddr,
    output logic [W-1:0] rdata
);
    localparam logic [5:0] NF_IDX = 6'(NF);

    logic [W-1:0] mem [2][NF];
    logic [W-1:0] rdata_d, rdata_q;

    always_ff @(posedge clk) begin
        if (we) mem[wbank][waddr] <= wdata;
    end

    // Out-of-range read addresses return zero rather than aliasing.
    always_comb begin
        rdata_d = '0;
        if (raddr < NF_IDX) rdata_d = mem[rbank][raddr];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) rdata_q <= '0;
        else        rdata_q <= rdata_d;
    end

    assign rdata = rdata_q;
endmodule

// File: rtl/mel_frame_scheduler.sv
// Per-frame MEL sequencer: start pulse, energy capture into a ping-pong bank, DCT handoff.
module mel_frame_scheduler #(
    parameter int NUM_FILTERS = mfcc_pkg::NUM_FILTERS,
    parameter int EW          = mfcc_pkg::EW,
    parameter int TIMEOUT_W   = mfcc_pkg::TIMEOUT_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 frame_ready_i,
    output logic                 frame_release_o,
    output logic                 mel_start_o,
    input  logic                 mel_done_i,
    input  logic [5:0]           mel_prt_i,
    input  logic [EW-1:0]        mel_value_i,
    input  logic [TIMEOUT_W-1:0] timeout_i,
    output logic                 bank_valid_o,
    output logic                 rd_bank_o,
    input  logic                 bank_free_i,
    input  logic [5:0]           rd_addr_i,
    output logic [EW-1:0]        rd_data_o,
    output logic                 busy_o,
    output logic                 error_o
);
    import mfcc_pkg::*;

    localparam logic [5:0] NF_IDX = 6'(NUM_FILTERS);

    sched_state_t           state_q, state_d;
    logic                   wr_bank_q, wr_bank_d;
    logic                   rd_bank_q, rd_bank_d;
    logic                   bank_valid_q, bank_valid_d;
    logic [1:0]             full_q, full_d;
    logic                   error_q, error_d;
    logic [TIMEOUT_W-1:0]   wdog_q, wdog_d;
    logic [NUM_FILTERS-1:0] mask_q, mask_d, mask_nxt;
    logic [5:0]             prev_prt_q, prev_prt_d;
    logic [EW-1:0]          prev_val_q, prev_val_d;
    logic                   we;

    always_comb begin
        state_d      = state_q;
        wr_bank_d    = wr_bank_q;
        rd_bank_d    = rd_bank_q;
        bank_valid_d = bank_valid_q;
        full_d       = full_q;
        error_d      = error_q;
        wdog_d       = wdog_q;
        prev_prt_d   = mel_prt_i;
        prev_val_d   = mel_value_i;
        mel_start_o     = 1'b0;
        frame_release_o = 1'b0;

        // An index is complete once MEL moves off it; the held value is the final one.
        we       = (state_q == RUN) && (mel_prt_i != prev_prt_q) && (prev_prt_q < NF_IDX);
        mask_nxt = mask_q;
        if (we) mask_nxt[prev_prt_q] = 1'b1;
        mask_d = mask_nxt;

        // Free is resolved before any handoff so a completing bank can be offered at once.
        if (bank_free_i && bank_valid_q) begin
            full_d[rd_bank_q] = 1'b0;
            if (full_q[!rd_bank_q]) rd_bank_d    = !rd_bank_q;
            else                    bank_valid_d = 1'b0;
        end

        unique case (state_q)
            IDLE: if (frame_ready_i && !full_q[wr_bank_q]) state_d = START;
            START: begin
                mel_start_o = 1'b1;
                wdog_d      = '0;
                mask_d      = '0;
                state_d     = RUN;
            end
            RUN: begin
                if (wdog_q != {TIMEOUT_W{1'b1}}) wdog_d = wdog_q + 1'b1;
                if (mel_done_i) begin
                    state_d = RELEASE;
                    mask_d  = '0;
                    if (&mask_nxt) begin
                        full_d[wr_bank_q] = 1'b1;
                        wr_bank_d         = !wr_bank_q;
                        if (!bank_valid_d) begin
                            bank_valid_d = 1'b1;
                            rd_bank_d    = wr_bank_q;
                        end
                    end
                end else if ((timeout_i != '0) && (wdog_q == timeout_i)) begin
                    state_d = RELEASE;
                    error_d = 1'b1;
                    mask_d  = '0;
                end
            end
            RELEASE: begin
                frame_release_o = 1'b1;
                state_d         = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            wr_bank_q    <= 1'b0;
            rd_bank_q    <= 1'b0;
            bank_valid_q <= 1'b0;
            full_q       <= '0;
            error_q      <= 1'b0;
            wdog_q       <= '0;
            mask_q       <= '0;
            prev_prt_q   <= 6'h3F;
            prev_val_q   <= '0;
        end else begin
            state_q      <= state_d;
            wr_bank_q    <= wr_bank_d;
            rd_bank_q    <= rd_bank_d;
            bank_valid_q <= bank_valid_d;
            full_q       <= full_d;
            error_q      <= error_d;
            wdog_q       <= wdog_d;
            mask_q       <= mask_d;
            prev_prt_q   <= prev_prt_d;
            prev_val_q   <= prev_val_d;
        end
    end

    energy_pingpong_ram #(.NF(NUM_FILTERS), .W(EW)) u_ram (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (we),
        .wbank (wr_bank_q),
        .waddr (prev_prt_q),
        .wdata (prev_val_q),
        .rbank (rd_bank_q),
        .raddr (rd_addr_i),
        .rdata (rd_data_o)
    );

    assign bank_valid_o = bank_valid_q;
    assign rd_bank_o    = rd_bank_q;
    assign busy_o       = (state_q != IDLE);
    assign error_o      = error_q;
endmodule

// File: tb/tb_mel_frame_scheduler.sv
// Directed bench for mel_frame_scheduler: per-scenario tasks with hand-computed expectations.
module tb_mel_frame_scheduler;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        frame_ready_i = 1'b0;
    logic        frame_release_o;
    logic        mel_start_o;
    logic        mel_done_i = 1'b0;
    logic [5:0]  mel_prt_i = 6'h3F;
    logic [8:0]  mel_value_i = '0;
    logic [15:0] timeout_i = '0;
    logic        bank_valid_o;
    logic        rd_bank_o;
    logic        bank_free_i = 1'b0;
    logic [5:0]  rd_addr_i = '0;
    logic [8:0]  rd_data_o;
    logic        busy_o;
    logic        error_o;

    int total = 0;
    int bad = 0;
    int start_cnt = 0;
    int rel_cnt = 0;

    mel_frame_scheduler dut (
        .clk(clk), .rst_n(rst_n), .frame_ready_i(frame_ready_i),
        .frame_release_o(frame_release_o), .mel_start_o(mel_start_o),
        .mel_done_i(mel_done_i), .mel_prt_i(mel_prt_i), .mel_value_i(mel_value_i),
        .timeout_i(timeout_i), .bank_valid_o(bank_valid_o), .rd_bank_o(rd_bank_o),
        .bank_free_i(bank_free_i), .rd_addr_i(rd_addr_i), .rd_data_o(rd_data_o),
        .busy_o(busy_o), .error_o(error_o)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mel_start_o) start_cnt++;
        if (frame_release_o) rel_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        frame_ready_i = 1'b0; mel_done_i = 1'b0; bank_free_i = 1'b0;
        mel_prt_i = 6'h3F; timeout_i = '0; rd_addr_i = '0;
        tick(); tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic wait_start(input string name);
        bit seen = 1'b0;
        frame_ready_i = 1'b1;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            if (mel_start_o) seen = 1'b1;
        end
        frame_ready_i = 1'b0;
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL %s start_timeout got=0 want=1", name);
        end
    endtask

    // MEL model: emits indices 0..39 (optionally skipping one), value 6*k+off, then done.
    task automatic mel_frame(input int skip, input int off, input bit free_at_done);
        for (int k = 0; k < 40; k++) begin
            if (k != skip) begin
                mel_prt_i = 6'(k);
                mel_value_i = 9'(6 * k + off);
                tick();
            end
        end
        mel_prt_i = 6'h3F;
        mel_done_i = 1'b1;
        bank_free_i = free_at_done;
        tick();
        mel_done_i = 1'b0;
        bank_free_i = 1'b0;
    endtask

    task automatic read_chk(input string name, input logic [5:0] addr, input logic [8:0] exp);
        rd_addr_i = addr;
        tick();
        total++;
        if (rd_data_o !== exp) begin
            bad++;
            $display("FAIL %s rd_data got=%0d want=%0d", name, rd_data_o, exp);
        end
    endtask

    task automatic free_pulse();
        bank_free_i = 1'b1;
        tick();
        bank_free_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        total++;
        if ({busy_o, bank_valid_o, rd_bank_o, error_o, mel_start_o, frame_release_o} !== 6'b0) begin
            bad++;
            $display("FAIL reset_flags got=%b want=000000",
                     {busy_o, bank_valid_o, rd_bank_o, error_o, mel_start_o, frame_release_o});
        end
        total++;
        if (rd_data_o !== 9'd0) begin
            bad++;
            $display("FAIL reset_rd_data got=%0d want=0", rd_data_o);
        end
        do_reset();
    endtask

    task automatic test_single();
        int s0, r0;
        do_reset();
        s0 = start_cnt; r0 = rel_cnt;
        wait_start("single");
        mel_frame(-1, 0, 1'b0);
        total++;
        if ({frame_release_o, bank_valid_o, rd_bank_o} !== 3'b110) begin
            bad++;
            $display("FAIL single_handoff got=%b want=110", {frame_release_o, bank_valid_o, rd_bank_o});
        end
        read_chk("single_addr5", 6'd5, 9'd30);
        read_chk("single_addr39", 6'd39, 9'd234);
        read_chk("single_addr0", 6'd0, 9'd0);
        total++;
        if ((start_cnt - s0) !== 1 || (rel_cnt - r0) !== 1) begin
            bad++;
            $display("FAIL single_pulses got=%0d/%0d want=1/1", start_cnt - s0, rel_cnt - r0);
        end
    endtask

    task automatic test_back_to_back();
        int s0;
        do_reset();
        wait_start("b2b_f1");
        mel_frame(-1, 0, 1'b0);
        tick();
        wait_start("b2b_f2");
        mel_frame(-1, 1, 1'b0);
        tick();
        total++;
        if ({bank_valid_o, rd_bank_o} !== 2'b10) begin
            bad++;
            $display("FAIL b2b_two_full got=%b want=10", {bank_valid_o, rd_bank_o});
        end
        s0 = start_cnt;
        frame_ready_i = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        total++;
        if ((start_cnt - s0) !== 0 || busy_o !== 1'b0) begin
            bad++;
            $display("FAIL b2b_holdoff got=%0d busy=%b want=0 busy=0", start_cnt - s0, busy_o);
        end
        frame_ready_i = 1'b0;
        free_pulse();
        total++;
        if ({bank_valid_o, rd_bank_o} !== 2'b11) begin
            bad++;
            $display("FAIL b2b_switch got=%b want=11", {bank_valid_o, rd_bank_o});
        end
        wait_start("b2b_f3");
        mel_frame(-1, 2, 1'b0);
        tick();
        read_chk("b2b_bank1", 6'd5, 9'd31);
        free_pulse();
        total++;
        if ({bank_valid_o, rd_bank_o} !== 2'b10) begin
            bad++;
            $display("FAIL b2b_switch_back got=%b want=10", {bank_valid_o, rd_bank_o});
        end
        read_chk("b2b_bank0_f3", 6'd5, 9'd32);
        free_pulse();
        total++;
        if (bank_valid_o !== 1'b0) begin
            bad++;
            $display("FAIL b2b_drained got=%b want=0", bank_valid_o);
        end
    endtask

    task automatic test_timeout();
        int n = 0;
        bit seen = 1'b0;
        do_reset();
        timeout_i = 16'd100;
        wait_start("timeout");
        while (!seen && n < 200) begin
            tick();
            n++;
            if (frame_release_o) seen = 1'b1;
        end
        total++;
        if (!seen || n < 101 || n > 102) begin
            bad++;
            $display("FAIL timeout_cycles got=%0d want=101..102", n);
        end
        total++;
        if ({error_o, bank_valid_o} !== 2'b10) begin
            bad++;
            $display("FAIL timeout_flags got=%b want=10", {error_o, bank_valid_o});
        end
        tick();
        wait_start("timeout_next");
        mel_frame(-1, 0, 1'b0);
        total++;
        if ({bank_valid_o, rd_bank_o, error_o} !== 3'b101) begin
            bad++;
            $display("FAIL timeout_next_bank got=%b want=101", {bank_valid_o, rd_bank_o, error_o});
        end
        read_chk("timeout_next_data", 6'd5, 9'd30);
    endtask

    task automatic test_skip();
        int r0;
        do_reset();
        r0 = rel_cnt;
        wait_start("skip");
        mel_frame(17, 0, 1'b0);
        tick();
        total++;
        if (bank_valid_o !== 1'b0 || (rel_cnt - r0) !== 1) begin
            bad++;
            $display("FAIL skip_drop got=%b rel=%0d want=0 rel=1", bank_valid_o, rel_cnt - r0);
        end
        wait_start("skip_next");
        mel_frame(-1, 5, 1'b0);
        total++;
        if ({bank_valid_o, rd_bank_o} !== 2'b10) begin
            bad++;
            $display("FAIL skip_next_bank got=%b want=10", {bank_valid_o, rd_bank_o});
        end
        read_chk("skip_next_data", 6'd17, 9'd107);
    endtask

    task automatic test_free_at_handoff();
        do_reset();
        wait_start("fah_f1");
        mel_frame(-1, 0, 1'b0);
        tick();
        wait_start("fah_f2");
        mel_frame(-1, 3, 1'b1);
        total++;
        if ({bank_valid_o, rd_bank_o} !== 2'b11) begin
            bad++;
            $display("FAIL fah_switch got=%b want=11", {bank_valid_o, rd_bank_o});
        end
        read_chk("fah_data", 6'd5, 9'd33);
    endtask

    task automatic test_reset_mid();
        int r0;
        do_reset();
        wait_start("mid");
        for (int k = 0; k <= 20; k++) begin
            mel_prt_i = 6'(k);
            mel_value_i = 9'(6 * k);
            tick();
        end
        r0 = rel_cnt;
        rst_n = 1'b0;
        tick();
        total++;
        if ({busy_o, bank_valid_o, rd_bank_o, error_o, frame_release_o} !== 5'b0 || rd_data_o !== 9'd0) begin
            bad++;
            $display("FAIL mid_reset_outputs got=%b/%0d want=00000/0",
                     {busy_o, bank_valid_o, rd_bank_o, error_o, frame_release_o}, rd_data_o);
        end
        rst_n = 1'b1;
        mel_prt_i = 6'h3F;
        tick(); tick();
        total++;
        if ((rel_cnt - r0) !== 0) begin
            bad++;
            $display("FAIL mid_no_release got=%0d want=0", rel_cnt - r0);
        end
        wait_start("mid_fresh");
        mel_frame(-1, 4, 1'b0);
        total++;
        if ({bank_valid_o, rd_bank_o} !== 2'b10) begin
            bad++;
            $display("FAIL mid_fresh_bank got=%b want=10", {bank_valid_o, rd_bank_o});
        end
        read_chk("mid_fresh_data", 6'd5, 9'd34);
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_timeout();
        test_skip();
        test_free_at_handoff();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
